// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low key matrix scanner with frame debounce and inactivity timeout
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE       = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       timeout,
    output logic       key_valid
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    NO_KEY     = 4'hF;

    localparam logic [1:0] S_RELEASED     = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [3:0]    r_row_s1, r_row_s2;
    logic [3:0]    r_row_c0, r_row_c1, r_row_c2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col_idx;
    logic [1:0]    r_state;
    logic [3:0]    r_last;
    logic [SW-1:0] r_stable;
    logic [TW-1:0] r_timer;
    logic          r_armed;

    logic          w_slot_end, w_frame_end;
    logic [15:0]   w_hit;
    logic [3:0]    w_result;
    logic [SW-1:0] w_stable_next;
    logic          w_stable_done;
    logic [1:0]    w_state_next;
    logic          w_accept_ok, w_accept;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:  key_code = 4'h1;
            4'd1:  key_code = 4'h2;
            4'd2:  key_code = 4'h3;
            4'd3:  key_code = 4'hA;
            4'd4:  key_code = 4'h4;
            4'd5:  key_code = 4'h5;
            4'd6:  key_code = 4'h6;
            4'd7:  key_code = 4'hB;
            4'd8:  key_code = 4'h7;
            4'd9:  key_code = 4'h8;
            4'd10: key_code = 4'h9;
            4'd11: key_code = 4'hC;
            4'd12: key_code = 4'hD;
            4'd13: key_code = 4'h0;
            default: key_code = 4'hE;
        endcase
    endfunction

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_slot_end  = (r_div == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
            r_row_c0  <= 4'hF;
            r_row_c1  <= 4'hF;
            r_row_c2  <= 4'hF;
            r_div     <= '0;
            r_col_idx <= 2'd0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            if (w_slot_end) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                case (r_col_idx)
                    2'd0:    r_row_c0 <= r_row_s2;
                    2'd1:    r_row_c1 <= r_row_s2;
                    2'd2:    r_row_c2 <= r_row_s2;
                    default: ;
                endcase
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    // Column 3 is consumed straight from the synchroniser on the frame-end cycle.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < 4; r++) begin
            w_hit[r*4 + 0] = ~r_row_c0[r];
            w_hit[r*4 + 1] = ~r_row_c1[r];
            w_hit[r*4 + 2] = ~r_row_c2[r];
            w_hit[r*4 + 3] = ~r_row_s2[r];
        end
    end

    always_comb begin
        w_result = NO_KEY;
        if (w_hit != 16'h0 && (w_hit & (w_hit - 16'd1)) == 16'h0) begin
            for (int i = 0; i < 16; i++) begin
                if (w_hit[i]) w_result = key_code(i[3:0]);
            end
        end
    end

    assign w_stable_next = (w_result != r_last) ? SW'(1) :
                           (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
    assign w_stable_done = (w_stable_next == STABLE_MAX);

    always_comb begin
        w_state_next = r_state;
        w_accept_ok  = 1'b0;
        case (r_state)
            S_RELEASED, S_PRESS_WAIT: begin
                if (w_result == NO_KEY) begin
                    w_state_next = S_RELEASED;
                end else if (w_stable_done) begin
                    w_accept_ok  = 1'b1;
                    w_state_next = S_PRESSED;
                end else begin
                    w_state_next = S_PRESS_WAIT;
                end
            end
            S_PRESSED: begin
                if (w_result == NO_KEY)
                    w_state_next = w_stable_done ? S_RELEASED : S_RELEASE_WAIT;
            end
            default: begin
                if (w_result != NO_KEY)  w_state_next = S_PRESSED;
                else if (w_stable_done)  w_state_next = S_RELEASED;
            end
        endcase
    end
    assign w_accept = w_frame_end && w_accept_ok;

    // An accept on the expiry cycle takes priority and simply reloads the timer.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= S_RELEASED;
            r_last    <= NO_KEY;
            r_stable  <= '0;
            r_timer   <= '0;
            r_armed   <= 1'b0;
            code      <= NO_KEY;
            key_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            key_valid <= w_accept;
            timeout   <= 1'b0;
            if (w_frame_end) begin
                r_state  <= w_state_next;
                r_last   <= w_result;
                r_stable <= w_stable_next;
            end
            if (w_accept) begin
                code    <= w_result;
                r_timer <= TIMER_LOAD;
                r_armed <= 1'b1;
            end else if (r_armed) begin
                if (r_timer == '0) begin
                    timeout <= 1'b1;
                    code    <= NO_KEY;
                    r_armed <= 1'b0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;
    localparam int SD  = 4;
    localparam int DB  = 2;
    localparam int TO1 = 200;
    localparam int TO2 = 192;
    localparam int FR  = 4 * SD;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  code;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] keys  = '0;
    logic [3:0]  row1, row2, col1, col2, code1, code2;
    logic        to1, to2, kv1, kv2;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int kv_seen  = 0;
    int to1_seen = 0;
    int to2_seen = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .TIMEOUT_CYCLES(TO1)) dut (
        .clk(clk), .reset(reset), .row(row1), .col(col1),
        .code(code1), .timeout(to1), .key_valid(kv1)
    );
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .TIMEOUT_CYCLES(TO2)) dut_c (
        .clk(clk), .reset(reset), .row(row2), .col(col2),
        .code(code2), .timeout(to2), .key_valid(kv2)
    );

    function automatic logic [3:0] matrix(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (k[i*4 + j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction
    assign row1 = matrix(col1, keys);
    assign row2 = matrix(col2, keys);

    function automatic logic [3:0] key_of(input int idx);
        case (idx)
            0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
            4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
            8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
           12: return 4'hD;  13: return 4'h0;  default: return 4'hE;
        endcase
    endfunction

    function automatic logic [3:0] frame_result(input logic [15:0] k);
        if ($countones(k) != 1) return 4'hF;
        for (int i = 0; i < 16; i++) if (k[i]) return key_of(i);
        return 4'hF;
    endfunction

    function automatic bit is_fend(input int n);
        return (n > 2) && ((n - 2) % FR == 0);
    endfunction

    function automatic logic [3:0] exp_col(input int n);
        int idx;
        idx = (n < 2) ? 0 : ((n - 2) / SD) % 4;
        return ~(4'b0001 << idx);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame-level key decisions, deadlines as absolute edge numbers.
    logic [3:0] hist[$];
    logic [3:0] res;
    logic [3:0] e_code1 = 4'hF;
    logic [3:0] e_code2 = 4'hF;
    bit locked = 0, arm1 = 0, arm2 = 0, e_kv = 0, e_to1 = 0, e_to2 = 0, all_same, all_f;
    int dl1 = 0, dl2 = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            edge_n = 0; hist.delete(); locked = 0; arm1 = 0; arm2 = 0;
            e_kv = 0; e_to1 = 0; e_to2 = 0; e_code1 = 4'hF; e_code2 = 4'hF;
        end else begin
            edge_n++;
            e_kv = 0; e_to1 = 0; e_to2 = 0;
            if (is_fend(edge_n)) begin
                res = frame_result(keys);
                hist.push_back(res);
                if (hist.size() > DB) void'(hist.pop_front());
                all_same = (hist.size() == DB);
                all_f    = (hist.size() == DB);
                foreach (hist[i]) begin
                    if (hist[i] != res)   all_same = 0;
                    if (hist[i] != 4'hF)  all_f = 0;
                end
                if (locked) begin
                    if (all_f) locked = 0;
                end else if (all_same && res != 4'hF) begin
                    e_kv = 1; locked = 1;
                    e_code1 = res; e_code2 = res;
                    arm1 = 1; arm2 = 1;
                    dl1 = edge_n + TO1; dl2 = edge_n + TO2;
                end
            end
            if (!e_kv && arm1 && edge_n == dl1) begin e_to1 = 1; e_code1 = 4'hF; arm1 = 0; end
            if (!e_kv && arm2 && edge_n == dl2) begin e_to2 = 1; e_code2 = 4'hF; arm2 = 0; end
        end
        #1;
        chk("col", col1, exp_col(edge_n));
        chk("col_c", col2, exp_col(edge_n));
        chk("code", code1, e_code1);
        chk("key_valid", kv1, e_kv);
        chk("timeout", to1, e_to1);
        chk("code_c", code2, e_code2);
        chk("key_valid_c", kv2, e_kv);
        chk("timeout_c", to2, e_to2);
        if (kv1) kv_seen++;
        if (to1) to1_seen++;
        if (to2) to2_seen++;
    end

    task automatic hold(input logic [15:0] k, input int nf);
        int guard;
        keys = k;
        for (int i = 0; i < nf; i++) begin
            guard = 0;
            do begin
                @(posedge clk);
                #2;
                guard++;
            end while (!is_fend(edge_n) && guard < 2 * FR);
            if (guard >= 2 * FR) begin
                n_assert++; n_fail++;
                $display("FAIL frame_sync: no frame end within %0d cycles", guard);
            end
        end
    endtask

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K4 = 16'h0010, K5 = 16'h0020;
    localparam logic [15:0] K6 = 16'h0040, K7 = 16'h0100, K8 = 16'h0200, K9 = 16'h0400;
    localparam logic [15:0] KB = 16'h0080, K0 = 16'h2000;

    vec_t        tbl[16];
    int          kv0, to0, toc0, a, b;
    logic [15:0] m;
    logic [15:0] seq_keys[5];

    initial begin
        tbl = '{'{16'h0001, 4'h1}, '{16'h0002, 4'h2}, '{16'h0004, 4'h3}, '{16'h0008, 4'hA},
                '{16'h0010, 4'h4}, '{16'h0020, 4'h5}, '{16'h0040, 4'h6}, '{16'h0080, 4'hB},
                '{16'h0100, 4'h7}, '{16'h0200, 4'h8}, '{16'h0400, 4'h9}, '{16'h0800, 4'hC},
                '{16'h1000, 4'hD}, '{16'h2000, 4'h0}, '{16'h4000, 4'hE}, '{16'h8000, 4'hE}};
        seq_keys = '{K2, K8, KB, K0, K4};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        hold(16'h0, 2);
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #2;
        chk("rst_col", col1, 4'b1110);
        chk("rst_code", code1, 4'hF);
        chk("rst_kv", kv1, 1'b0);
        chk("rst_to", to1, 1'b0);
        @(negedge clk) reset = 1'b1;
        kv0 = kv_seen; to0 = to1_seen;
        hold(16'h0, 63);
        chk("idle_kv_count", 4'(kv_seen - kv0), 4'd0);
        chk("idle_to_count", 4'(to1_seen - to0), 4'd0);

        foreach (tbl[i]) begin
            hold(16'h0, 2);
            hold(tbl[i].mask, 2);
            chk("table_code", code1, tbl[i].code);
            chk("table_kv", kv1, 1'b1);
        end

        hold(16'h0, 2);
        kv0 = kv_seen; to0 = to1_seen;
        hold(K2, 2);
        chk("single_kv", kv1, 1'b1);
        chk("single_code", code1, 4'h2);
        hold(K2, 1);
        hold(16'h0, 14);
        chk("single_kv_count", 4'(kv_seen - kv0), 4'd1);
        chk("single_to_count", 4'(to1_seen - to0), 4'd1);
        chk("single_code_after", code1, 4'hF);

        kv0 = kv_seen; to0 = to1_seen;
        foreach (seq_keys[i]) begin
            hold(seq_keys[i], 3);
            hold(16'h0, 2);
        end
        chk("seq_kv_count", 4'(kv_seen - kv0), 4'd5);
        chk("seq_to_count", 4'(to1_seen - to0), 4'd0);
        chk("seq_code", code1, 4'h4);
        hold(16'h0, 13);
        chk("seq_to_after", 4'(to1_seen - to0), 4'd1);

        kv0 = kv_seen;
        for (int i = 0; i < 3; i++) begin
            hold(K5, 1);
            hold(16'h0, 1);
        end
        chk("bounce_kv_count", 4'(kv_seen - kv0), 4'd0);
        hold(K5, 3);
        chk("bounce_accept", 4'(kv_seen - kv0), 4'd1);
        chk("bounce_code", code1, 4'h5);

        hold(16'h0, 3);
        kv0 = kv_seen;
        hold(K1 | K4, 3);
        chk("ghost_kv_count", 4'(kv_seen - kv0), 4'd0);
        hold(K7, 3);
        hold(K7 | K9, 3);
        chk("rollover_kv_count", 4'(kv_seen - kv0), 4'd1);
        chk("rollover_code", code1, 4'h7);

        hold(16'h0, 14);
        hold(K8, 2);
        chk("collide_first_kv", kv2, 1'b1);
        hold(16'h0, 10);
        toc0 = to2_seen;
        hold(K8, 2);
        chk("collide_kv", kv2, 1'b1);
        chk("collide_to", to2, 1'b0);
        chk("collide_code", code2, 4'h8);
        hold(16'h0, 13);
        chk("collide_next_to", 4'(to2_seen - toc0), 4'd1);
        chk("collide_code_after", code2, 4'hF);

        hold(K5, 2);
        hold(16'h0, 2);
        #1 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        to0 = to1_seen;
        hold(16'h0, 15);
        chk("rst_timer_to_count", 4'(to1_seen - to0), 4'd0);
        chk("rst_timer_code", code1, 4'hF);

        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 3))
                0: m = 16'h0;
                1, 2: m = 16'h1 << $urandom_range(0, 15);
                default: begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    m = (16'h1 << a) | (16'h1 << b);
                end
            endcase
            hold(m, $urandom_range(1, 4));
        end
        hold(16'h0, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_assert++; n_fail++;
        $display("FAIL watchdog: test still running at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
